// File: rtl/enemy_spawn_scheduler.sv
// Timed enemy spawn sequencer walking the per-level queue ROM.
// Optional macro ENEMY_CAP_EN stalls issuing while alive_cnt >= ENEMY_CAP.
`timescale 1ns/1ps
module enemy_spawn_scheduler #(
    parameter int QUEUE_DEPTH = 64,
    parameter int ROM_LAT     = 1,
    parameter int ENEMY_CAP   = 6
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  level,
    input  logic        frame_tick,
    input  logic        halt,
    output logic [7:0]  rom_addr,
    input  logic [14:0] rom_data,
    output logic        spawn_valid,
    output logic [2:0]  spawn_type,
    input  logic        spawn_ready,
    input  logic [3:0]  alive_cnt,
    output logic [11:0] frame_cnt,
    output logic        queue_done,
    output logic        busy
);
    localparam int IW = $clog2(QUEUE_DEPTH + 1);
    localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, WAIT, ISSUE, DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [LW-1:0] lat_cnt;
    logic [11:0]   ts_r;
    logic [2:0]    type_r;
    logic [1:0]    lvl_m1;
    logic [7:0]    base;
    logic [11:0]   rom_ts;
    logic [2:0]    rom_type;
    logic          cap_ok;

    assign rom_ts   = rom_data[14:3];
    assign rom_type = rom_data[2:0];
    assign lvl_m1   = (level == 2'd0) ? 2'd0 : level - 2'd1;
    assign base     = 8'(QUEUE_DEPTH * int'(lvl_m1));

`ifdef ENEMY_CAP_EN
    assign cap_ok = alive_cnt < 4'(ENEMY_CAP);
`else
    logic unused_alive;
    assign unused_alive = ^alive_cnt;
    assign cap_ok = 1'b1;
`endif

    // Due entries seen at LATCH go straight to ISSUE so back-to-back
    // spawns are ROM_LAT+2 cycles apart.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            lat_cnt     <= '0;
            ts_r        <= '0;
            type_r      <= '0;
            rom_addr    <= '0;
            spawn_valid <= 1'b0;
            spawn_type  <= '0;
            frame_cnt   <= '0;
            queue_done  <= 1'b0;
            busy        <= 1'b0;
        end else if (halt) begin
            state       <= IDLE;
            spawn_valid <= 1'b0;
            queue_done  <= 1'b0;
            busy        <= 1'b0;
        end else if (start) begin
            state       <= FETCH;
            idx         <= '0;
            lat_cnt     <= '0;
            frame_cnt   <= '0;
            rom_addr    <= base;
            spawn_valid <= 1'b0;
            queue_done  <= 1'b0;
            busy        <= 1'b1;
        end else begin
            if (state != IDLE && frame_tick && frame_cnt != 12'hFFF)
                frame_cnt <= frame_cnt + 12'd1;
            case (state)
                IDLE: ;
                FETCH: begin
                    if (lat_cnt == LW'(ROM_LAT - 1)) begin
                        lat_cnt <= '0;
                        state   <= LATCH;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    ts_r   <= rom_ts;
                    type_r <= rom_type;
                    if (rom_type == 3'b111) begin
                        state      <= DONE;
                        queue_done <= 1'b1;
                    end else if (frame_cnt >= rom_ts && cap_ok) begin
                        state       <= ISSUE;
                        spawn_valid <= 1'b1;
                        spawn_type  <= rom_type;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (frame_cnt >= ts_r && cap_ok) begin
                        state       <= ISSUE;
                        spawn_valid <= 1'b1;
                        spawn_type  <= type_r;
                    end
                end
                ISSUE: begin
                    if (spawn_ready) begin
                        spawn_valid <= 1'b0;
                        idx         <= idx + 1'b1;
                        if (idx == IW'(QUEUE_DEPTH - 1)) begin
                            state      <= DONE;
                            queue_done <= 1'b1;
                        end else begin
                            rom_addr <= rom_addr + 8'd1;
                            state    <= FETCH;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
